combo_lock_ctrl: RTL

//   Sequencing controller for the keypad combination lock. Consumes debounced key events
//   (key_code/key_valid from the keypad scanner board) and collects entered digits.

---
 rtl/combo_lock_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/combo_lock_ctrl.sv
// Keypad combination lock sequencer: collects digits from key presses, checks them
// against a stored code, and handles code change, error hold-off and timed lockout.
module combo_lock_ctrl #(
  parameter int                      N_DIGITS       = 4,
  parameter logic [4*N_DIGITS-1:0]   DEFAULT_CODE   = 16'h1234,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      ERR_CYCLES     = 25000000,
  parameter int                      LOCKOUT_CYCLES = 500000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        key_code,
  input  logic                              key_valid,
  output logic                              unlocked,
  output logic                              error,
  output logic                              lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_count,
  output logic [$clog2(N_DIGITS+1)-1:0]     digit_count,
  output logic [4*N_DIGITS-1:0]             entry,
  output logic [2:0]                        state
);

  localparam int EW      = 4 * N_DIGITS;
  localparam int FCW     = $clog2(MAX_FAILS + 1);
  localparam int DCW     = $clog2(N_DIGITS + 1);
  localparam int MAX_CYC = (ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]  ERR_LOAD  = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0]  LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FCW-1:0] FC_MAX    = FCW'(MAX_FAILS);
  localparam logic [DCW-1:0] DC_FULL   = DCW'(N_DIGITS);

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_OPEN    = 3'd1,
    S_SET     = 3'd2,
    S_ERROR   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t         r_state, w_state_nx;
  logic [EW-1:0]  r_code, w_code_nx;
  logic [EW-1:0]  r_entry, w_entry_nx;
  logic [DCW-1:0] r_digit_count, w_dc_nx;
  logic [FCW-1:0] r_fail_count, w_fc_nx;
  logic [TW-1:0]  r_timer, w_timer_nx;
  logic           r_key_valid_q;

  logic           w_press;
  logic           w_is_digit;
  logic           w_full;
  logic [FCW-1:0] w_fail_inc;

  // A press is the rising edge of key_valid, so a held key yields one event only.
  assign w_press    = key_valid & ~r_key_valid_q;
  assign w_is_digit = (key_code <= 4'd9);
  assign w_full     = (r_digit_count == DC_FULL);
  assign w_fail_inc = (r_fail_count == FC_MAX) ? FC_MAX : r_fail_count + 1'b1;

  // NOTE: every next-value signal gets its hold value first, so no path infers a latch.
  always_comb begin
    w_state_nx = r_state;
    w_code_nx  = r_code;
    w_entry_nx = r_entry;
    w_dc_nx    = r_digit_count;
    w_fc_nx    = r_fail_count;
    w_timer_nx = r_timer;
    case (r_state)
      S_LOCKED, S_SET: begin
        if (w_press) begin
          if (w_is_digit) begin
            if (!w_full) begin
              w_entry_nx = (r_entry << 4) | EW'(key_code);
              w_dc_nx    = r_digit_count + 1'b1;
            end
          end else if (key_code == 4'hB) begin
            w_entry_nx = '0;
            w_dc_nx    = '0;
          end else if (key_code == 4'hA) begin
            if (r_state == S_LOCKED) begin
              w_entry_nx = '0;
              w_dc_nx    = '0;
              if (w_full && r_entry == r_code) begin
                w_state_nx = S_OPEN;
                w_fc_nx    = '0;
              end else begin
                w_fc_nx = w_fail_inc;
                if (w_fail_inc == FC_MAX) begin
                  w_state_nx = S_LOCKOUT;
                  w_timer_nx = LOCK_LOAD;
                end else begin
                  w_state_nx = S_ERROR;
                  w_timer_nx = ERR_LOAD;
                end
              end
            end else if (w_full) begin
              w_code_nx  = r_entry;
              w_entry_nx = '0;
              w_dc_nx    = '0;
              w_state_nx = S_OPEN;
            end
          end else if (key_code == 4'hF && r_state == S_SET) begin
            w_entry_nx = '0;
            w_dc_nx    = '0;
            w_state_nx = S_OPEN;
          end
        end
      end
      S_OPEN: begin
        if (w_press && (key_code == 4'hF || key_code == 4'hC)) begin
          w_entry_nx = '0;
          w_dc_nx    = '0;
          w_state_nx = (key_code == 4'hF) ? S_LOCKED : S_SET;
        end
      end
      S_ERROR: begin
        if (r_timer == '0) w_state_nx = S_LOCKED;
        else               w_timer_nx = r_timer - 1'b1;
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nx = S_LOCKED;
          w_fc_nx    = '0;
        end else begin
          w_timer_nx = r_timer - 1'b1;
        end
      end
      default: w_state_nx = S_LOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_LOCKED;
      r_code        <= DEFAULT_CODE;
      r_entry       <= '0;
      r_digit_count <= '0;
      r_fail_count  <= '0;
      r_timer       <= '0;
      r_key_valid_q <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_code        <= w_code_nx;
      r_entry       <= w_entry_nx;
      r_digit_count <= w_dc_nx;
      r_fail_count  <= w_fc_nx;
      r_timer       <= w_timer_nx;
      r_key_valid_q <= key_valid;
    end
  end

  assign unlocked    = (r_state == S_OPEN) || (r_state == S_SET);
  assign error       = (r_state == S_ERROR);
  assign lockout     = (r_state == S_LOCKOUT);
  assign fail_count  = r_fail_count;
  assign digit_count = r_digit_count;
  assign entry       = r_entry;
  assign state       = r_state;

endmodule
